// File: rtl/crc_fault_engine.sv
// Framed CRC engine with a golden datapath and a fault-injected datapath running in parallel.
// Each frame yields both CRCs, a mismatch flag, and saturating frame/detection counters.
module crc_fault_engine #(
   parameter int                DATA_W = 16,
   parameter int                CRC_W  = 16,
   parameter logic [CRC_W-1:0]  POLY   = 16'h1021,
   parameter logic [CRC_W-1:0]  INIT   = 16'hFFFF,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_last,
   input  logic [1:0]        fault_mode,
   input  logic [DATA_W-1:0] fault_mask,
   input  logic [DATA_W-1:0] fault_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CRC_W-1:0]  crc_golden,
   output logic [CRC_W-1:0]  crc_faulty,
   output logic              mismatch,
   input  logic              clear_cnt,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  detect_cnt
);

   // state    | meaning
   // S_IDLE   | waiting for the first beat of a frame
   // S_ACCUM  | mid-frame, accumulating beats
   // S_RESULT | presenting both CRCs until the consumer takes them
   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_t;

   state_t              state, state_nxt;
   logic                armed;
   logic [1:0]          mode_q;
   logic [DATA_W-1:0]   mask_q, value_q;
   logic [1:0]          mode_eff;
   logic [DATA_W-1:0]   mask_eff, value_eff, data_f;
   logic [CRC_W-1:0]    base_g, base_f;
   logic                first_beat, accept, handshake;

   function automatic logic [CRC_W-1:0] crc_update(input logic [CRC_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
      logic [CRC_W-1:0] r;
      logic             fb;
      r = c;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = r[CRC_W-1] ^ d[i];
         r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE, S_ACCUM: begin
            in_ready = armed;
            if (in_valid && armed) state_nxt = in_last ? S_RESULT : S_ACCUM;
         end
         S_RESULT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign first_beat = (state == S_IDLE);
   assign accept     = in_valid & in_ready;
   assign handshake  = out_valid & out_ready;

   // The first beat uses the live config since it is being latched on that same edge.
   assign mode_eff  = first_beat ? fault_mode  : mode_q;
   assign mask_eff  = first_beat ? fault_mask  : mask_q;
   assign value_eff = first_beat ? fault_value : value_q;

   always_comb begin
      data_f = data_in;
      case (mode_eff)
         2'd1:    data_f = (data_in & ~mask_eff) | (value_eff & mask_eff);
         2'd2:    data_f = first_beat ? (data_in ^ mask_eff) : data_in;
         2'd3:    data_f = data_in ^ mask_eff;
         default: data_f = data_in;
      endcase
   end

   assign base_g   = first_beat ? INIT : crc_golden;
   assign base_f   = first_beat ? INIT : crc_faulty;
   assign mismatch = (crc_golden != crc_faulty);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         armed      <= 1'b0;
         mode_q     <= '0;
         mask_q     <= '0;
         value_q    <= '0;
         crc_golden <= '0;
         crc_faulty <= '0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
         if (accept) begin
            crc_golden <= crc_update(base_g, data_in);
            crc_faulty <= crc_update(base_f, data_f);
            if (first_beat) begin
               mode_q  <= fault_mode;
               mask_q  <= fault_mask;
               value_q <= fault_value;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt  <= '0;
         detect_cnt <= '0;
      end else if (clear_cnt) begin
         frame_cnt  <= '0;
         detect_cnt <= '0;
      end else if (handshake) begin
         if (frame_cnt != '1)               frame_cnt  <= frame_cnt + 1'b1;
         if (mismatch && detect_cnt != '1) detect_cnt <= detect_cnt + 1'b1;
      end
   end

endmodule
